// File: rtl/wb_arb_pkg.sv
// Shared definitions for the register-file write-port arbiter:
// FSM state encodings and default sizing constants.
package wb_arb_pkg;

  localparam int unsigned DEF_FIFO_DEPTH = 4;
  localparam int unsigned DEF_MAX_WAIT   = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    STEAL = 2'd2
  } arb_state_t;

endpackage

// File: rtl/wb_arb_fifo.sv
// Synchronous FIFO for buffered debug register writes ({addr, data}).
// Exposes full/empty/occupancy and accepts push and pop in the same cycle.
module wb_arb_fifo
  import wb_arb_pkg::*;
#(
  parameter int unsigned WIDTH = 37,
  parameter int unsigned DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];

  // Pointer and occupancy tracking; reset drops all queued entries
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage; contents are only meaningful between the pointers
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/wb_regfile_write_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority with zero
// added latency; debug writes queue in a FIFO and drain into idle slots.
// Build option WB_ARB_STARVE_EN adds a starvation counter that steals one
// writeback slot (via o_stall_req) when the FIFO head has waited MAX_WAIT cycles.
module wb_regfile_write_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned BITS_SIZE  = 32,
  parameter int unsigned BITS_REGS  = 5,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int unsigned MAX_WAIT   = DEF_MAX_WAIT
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_wb_reg_write,
  input  logic [BITS_REGS-1:0]          i_wb_addr,
  input  logic [BITS_SIZE-1:0]          i_wb_data,
  input  logic                          i_dbg_valid,
  input  logic [BITS_REGS-1:0]          i_dbg_addr,
  input  logic [BITS_SIZE-1:0]          i_dbg_data,
  output logic                          o_dbg_ready,
  output logic                          o_rf_write,
  output logic [BITS_REGS-1:0]          o_rf_addr,
  output logic [BITS_SIZE-1:0]          o_rf_data,
  output logic                          o_stall_req,
  output logic [$clog2(FIFO_DEPTH):0]   o_dbg_pending
);

  localparam int unsigned EW = BITS_REGS + BITS_SIZE;
  localparam int unsigned PW = $clog2(FIFO_DEPTH) + 1;

  logic [EW-1:0]        w_head;
  logic [BITS_REGS-1:0] w_head_addr;
  logic [BITS_SIZE-1:0] w_head_data;
  logic                 w_full;
  logic                 w_empty;
  logic [PW-1:0]        w_count;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_pipe_busy;
  logic                 w_last_pop;
  logic                 w_steal;
  arb_state_t           r_state;

  assign w_head_addr   = w_head[EW-1 -: BITS_REGS];
  assign w_head_data   = w_head[BITS_SIZE-1:0];
  assign w_push        = i_dbg_valid && !w_full;
  assign w_pipe_busy   = i_wb_reg_write && (i_wb_addr != '0);
  // FIFO goes empty at the next edge: last entry leaves and nothing arrives
  assign w_last_pop    = w_pop && !w_push && (w_count == PW'(1));
  assign o_dbg_ready   = !w_full;
  assign o_dbg_pending = w_count;
  assign o_stall_req   = w_steal;

  wb_arb_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (w_push),
    .i_data  ({i_dbg_addr, i_dbg_data}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Write-port selection: stolen slot, then pipeline, then idle-slot drain
  always_comb begin
    w_pop      = 1'b0;
    o_rf_write = 1'b0;
    o_rf_addr  = '0;
    o_rf_data  = '0;
    if (!i_reset) begin
      if (w_steal) begin
        w_pop      = !w_empty;
        o_rf_write = !w_empty && (w_head_addr != '0);
        o_rf_addr  = w_head_addr;
        o_rf_data  = w_head_data;
      end else if (w_pipe_busy) begin
        o_rf_write = 1'b1;
        o_rf_addr  = i_wb_addr;
        o_rf_data  = i_wb_data;
      end else if (!w_empty) begin
        w_pop      = 1'b1;
        o_rf_write = (w_head_addr != '0);
        o_rf_addr  = w_head_addr;
        o_rf_data  = w_head_data;
      end
    end
  end

`ifdef WB_ARB_STARVE_EN
  localparam int unsigned CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

  logic [CW-1:0] r_wait_cnt;
  logic          r_stall;

  assign w_steal = r_stall;

  // Starvation FSM: counts unpopped head cycles and requests a one-cycle steal
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= IDLE;
      r_wait_cnt <= '0;
      r_stall    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_push) r_state <= WAIT;
        end
        WAIT: begin
          if (w_pop) begin
            r_wait_cnt <= '0;
            if (w_last_pop) r_state <= IDLE;
          end else if (r_wait_cnt == CW'(MAX_WAIT - 1)) begin
            r_wait_cnt <= '0;
            r_stall    <= 1'b1;
            r_state    <= STEAL;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        STEAL: begin
          r_stall    <= 1'b0;
          r_wait_cnt <= '0;
          r_state    <= w_last_pop ? IDLE : WAIT;
        end
        default: begin
          r_state    <= IDLE;
          r_wait_cnt <= '0;
          r_stall    <= 1'b0;
        end
      endcase
    end
  end
`else
  // MAX_WAIT has no role without starvation protection
  logic w_unused_max_wait;
  assign w_unused_max_wait = (MAX_WAIT == 0);
  assign w_steal           = 1'b0;

  // Occupancy FSM only: debug writes drain on idle slots, no slot stealing
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE:    if (w_push) r_state <= WAIT;
        WAIT:    if (w_last_pop) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_wb_regfile_write_arbiter.sv
// Self-checking bench for wb_regfile_write_arbiter. A reference model keeps the
// accepted debug writes in a queue and predicts ready/pending/stall and the
// write-port result for every cycle; predicted writes are popped and compared.
module tb_wb_regfile_write_arbiter;
  import wb_arb_pkg::*;

  localparam int unsigned BS    = 32;
  localparam int unsigned BR    = 5;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned MW    = 8;
`ifdef WB_ARB_STARVE_EN
  localparam bit STARVE = 1'b1;
`else
  localparam bit STARVE = 1'b0;
`endif

  logic                      i_clk;
  logic                      i_reset;
  logic                      i_wb_reg_write;
  logic [BR-1:0]             i_wb_addr;
  logic [BS-1:0]             i_wb_data;
  logic                      i_dbg_valid;
  logic [BR-1:0]             i_dbg_addr;
  logic [BS-1:0]             i_dbg_data;
  logic                      o_dbg_ready;
  logic                      o_rf_write;
  logic [BR-1:0]             o_rf_addr;
  logic [BS-1:0]             o_rf_data;
  logic                      o_stall_req;
  logic [$clog2(DEPTH):0]    o_dbg_pending;

  typedef struct packed {
    logic [BR-1:0] a;
    logic [BS-1:0] d;
  } ent_t;

  ent_t        sbq[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_stall = 0;
  int unsigned m_age   = 0;
  bit          m_stall = 1'b0;

  wb_regfile_write_arbiter #(
    .BITS_SIZE  (BS),
    .BITS_REGS  (BR),
    .FIFO_DEPTH (DEPTH),
    .MAX_WAIT   (MW)
  ) u_dut (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_wb_reg_write (i_wb_reg_write),
    .i_wb_addr      (i_wb_addr),
    .i_wb_data      (i_wb_data),
    .i_dbg_valid    (i_dbg_valid),
    .i_dbg_addr     (i_dbg_addr),
    .i_dbg_data     (i_dbg_data),
    .o_dbg_ready    (o_dbg_ready),
    .o_rf_write     (o_rf_write),
    .o_rf_addr      (o_rf_addr),
    .o_rf_data      (o_rf_data),
    .o_stall_req    (o_stall_req),
    .o_dbg_pending  (o_dbg_pending)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // One clock cycle: drive after the edge, sample and compare at the falling edge
  task automatic step(input logic wb, input logic [BR-1:0] wa, input logic [BS-1:0] wd,
                      input logic dv, input logic [BR-1:0] da, input logic [BS-1:0] dd,
                      output bit acc);
    ent_t        e;
    logic        exp_w;
    logic [BR-1:0] ea;
    logic [BS-1:0] ed;
    bit          popped;
    bit          head;
    bit          exp_ready;
    @(posedge i_clk);
    #1;
    i_wb_reg_write = wb;
    i_wb_addr      = wa;
    i_wb_data      = wd;
    i_dbg_valid    = dv;
    i_dbg_addr     = da;
    i_dbg_data     = dd;
    @(negedge i_clk);
    exp_ready = (sbq.size() < DEPTH);
    head      = (sbq.size() > 0);
    popped    = 1'b0;
    exp_w     = 1'b0;
    ea        = '0;
    ed        = '0;
    check("dbg_ready", o_dbg_ready, exp_ready);
    check("dbg_pending", o_dbg_pending, sbq.size());
    check("stall_req", o_stall_req, m_stall);
    if (o_stall_req) n_stall++;
    if (m_stall && head) begin
      e = sbq.pop_front(); popped = 1'b1;
      exp_w = (e.a != '0); ea = e.a; ed = e.d;
    end else if (wb && wa != '0) begin
      exp_w = 1'b1; ea = wa; ed = wd;
    end else if (head) begin
      e = sbq.pop_front(); popped = 1'b1;
      exp_w = (e.a != '0); ea = e.a; ed = e.d;
    end
    check("rf_write", o_rf_write, exp_w);
    if (exp_w) begin
      check("rf_addr", o_rf_addr, ea);
      check("rf_data", o_rf_data, ed);
    end
    // Head age: cycles visible without being popped; steal follows age MW
    if (head && !popped) begin
      m_age++;
      m_stall = STARVE && (m_age == MW);
    end else begin
      m_age   = 0;
      m_stall = 1'b0;
    end
    acc = dv && exp_ready;
    if (acc) sbq.push_back('{a: da, d: dd});
  endtask

  task automatic do_reset();
    @(posedge i_clk);
    #1;
    i_reset        = 1'b1;
    i_wb_reg_write = 1'b1;
    i_wb_addr      = 5'd3;
    i_wb_data      = 32'h77;
    i_dbg_valid    = 1'b1;
    @(negedge i_clk);
    check("rst_rf_write", o_rf_write, 1'b0);
    check("rst_ready", o_dbg_ready, 1'b1);
    check("rst_pending", o_dbg_pending, 0);
    check("rst_stall", o_stall_req, 1'b0);
    check("rst_fsm", u_dut.r_state, IDLE);
    sbq.delete();
    m_age   = 0;
    m_stall = 1'b0;
    @(posedge i_clk);
    #1;
    i_reset        = 1'b0;
    i_wb_reg_write = 1'b0;
    i_wb_addr      = '0;
    i_wb_data      = '0;
    i_dbg_valid    = 1'b0;
    i_dbg_addr     = '0;
    i_dbg_data     = '0;
  endtask

  initial begin
    bit acc;
    int n_acc;
    int stall0;
    int k;
    bit was_stall;
    i_reset = 1'b1;
    i_wb_reg_write = 1'b0; i_wb_addr = '0; i_wb_data = '0;
    i_dbg_valid = 1'b0; i_dbg_addr = '0; i_dbg_data = '0;
    do_reset();

    // Pipeline write passes through in the same cycle
    step(1'b1, 5'd5, 32'h1234, 1'b0, '0, '0, acc);
    check("pipe_stall", o_stall_req, 1'b0);

    // Debug write drains on the next idle slot
    step(1'b0, '0, '0, 1'b1, 5'd7, 32'hCAFE, acc);
    check("dbg_acc", acc, 1'b1);
    step(1'b0, '0, '0, 1'b0, '0, '0, acc);
    check("dbg_wr_r7", {o_rf_write, o_rf_addr, o_rf_data}, {1'b1, 5'd7, 32'hCAFE});
    step(1'b0, '0, '0, 1'b0, '0, '0, acc);
    check("dbg_pend_0", o_dbg_pending, 0);

    // Fill the FIFO behind a busy pipeline; fifth request is refused
    n_acc = 0;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 5'd1 + 5'(i), 32'hA000 + i, 1'b1, 5'd10 + 5'(i), 32'hD000 + i, acc);
      if (acc) n_acc++;
    end
    check("fill_ready", o_dbg_ready, 1'b0);
    check("fill_accepts", n_acc, 4);
    for (int i = 0; i < 5; i++) step(1'b0, '0, '0, 1'b0, '0, '0, acc);
    check("fill_drained", sbq.size(), 0);

    // Continuous pipeline writes with one queued entry
    stall0 = n_stall;
    k = 0;
    step(1'b1, 5'd9, 32'h1000, 1'b1, 5'd12, 32'hBEEF, acc);
    k = 1;
    for (int i = 0; i < 14; i++) begin
      was_stall = m_stall;
      step(1'b1, 5'd9, 32'h1000 + k, 1'b0, '0, '0, acc);
      if (!was_stall) k++;
    end
    check("starve_pulses", n_stall - stall0, STARVE ? 1 : 0);
    step(1'b0, '0, '0, 1'b0, '0, '0, acc);
    step(1'b0, '0, '0, 1'b0, '0, '0, acc);
    check("starve_drained", sbq.size(), 0);

    // Debug write to r0 is popped without a write
    step(1'b0, '0, '0, 1'b1, 5'd0, 32'h55, acc);
    step(1'b0, '0, '0, 1'b0, '0, '0, acc);
    check("r0_no_write", o_rf_write, 1'b0);
    step(1'b0, '0, '0, 1'b0, '0, '0, acc);
    check("r0_pend_0", o_dbg_pending, 0);

    // Pipeline write to r0 counts as an idle slot
    step(1'b0, '0, '0, 1'b1, 5'd9, 32'h99, acc);
    step(1'b1, 5'd0, 32'hDEAD, 1'b0, '0, '0, acc);
    check("wb_r0_drain", {o_rf_write, o_rf_addr}, {1'b1, 5'd9});

    // Reset with three entries queued drops them all
    for (int i = 0; i < 3; i++)
      step(1'b1, 5'd2, 32'hB000 + i, 1'b1, 5'd20 + 5'(i), 32'hE000 + i, acc);
    check("pre_rst_pend", o_dbg_pending, 2);
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b0, '0, '0, 1'b0, '0, '0, acc);
    check("post_rst_pend", o_dbg_pending, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
